// File: rtl/ntt_stream_gearbox.sv
// Gearbox between a LANES-wide host stream and the NTT core's full-vector port.
// Gathers beats into vectors on the way in; ping-pong buffers and serialises core results on the way out.
module ntt_stream_gearbox #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32,
  parameter int LANES                = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  s_valid,
  input  logic                                                  s_first,
  input  logic [LANES*DATA_WIDTH_PER_INPUT-1:0]                 s_data,
  output logic                                                  core_in_start,
  output logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]  core_in_data,
  input  logic                                                  core_out_start,
  input  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]  core_out_data,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic [LANES*DATA_WIDTH_PER_INPUT-1:0]                 m_data,
  output logic                                                  m_first,
  output logic                                                  m_last,
  output logic                                                  sync_err,
  output logic                                                  overflow
);
  localparam int DW    = DATA_WIDTH_PER_INPUT;
  localparam int BEATS = INPUT_PER_CYCLE / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Beat-major view of a vector: entry b holds coefficients [b*LANES +: LANES].
  typedef logic [BEATS-1:0][LANES*DW-1:0] beats_t;
  typedef enum logic {IDLE, SEND} state_t;

  // ---------------- input gather ----------------
  logic [BW-1:0] in_cnt_q, in_cnt_d, in_idx;
  beats_t        asm_q, asm_d;
  logic          in_done;
  logic          cin_start_q;
  beats_t        cin_data_q;
  logic          sync_q;

  always_comb begin
    in_idx   = s_first ? '0 : in_cnt_q;
    asm_d    = asm_q;
    in_cnt_d = in_cnt_q;
    in_done  = 1'b0;
    if (s_valid) begin
      asm_d[in_idx] = s_data;
      if (in_idx == BW'(BEATS-1)) begin
        in_cnt_d = '0;
        in_done  = 1'b1;
      end else begin
        in_cnt_d = in_idx + 1'b1;
      end
    end
  end

  // ---------------- output buffer + serialiser ----------------
  logic [1:0][INPUT_PER_CYCLE-1:0][DW-1:0] buf_q;
  logic          wr_sel_q, rd_sel_q;
  logic [1:0]    cnt_q, cnt_d;
  logic [BW-1:0] out_cnt_q, out_cnt_d;
  state_t        state_q, state_d;
  logic          ovf_q;
  logic          hs, last_beat, release_s, capture, drop;
  beats_t        rd_beats;

  assign m_valid   = (state_q == SEND);
  assign hs        = m_valid & m_ready;
  assign last_beat = (out_cnt_q == BW'(BEATS-1));
  assign release_s = hs & last_beat;
  // A slot freed on this very edge may be refilled on the same edge.
  assign capture   = core_out_start & ((cnt_q != 2'd2) | release_s);
  assign drop      = core_out_start & ~capture;
  assign cnt_d     = cnt_q + {1'b0, capture} - {1'b0, release_s};

  always_comb begin
    state_d   = state_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      IDLE: if (cnt_d != 2'd0) state_d = SEND;
      SEND: if (hs) begin
        out_cnt_d = last_beat ? '0 : out_cnt_q + 1'b1;
        if (release_s && cnt_d == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_beats = buf_q[rd_sel_q];
  assign m_data   = m_valid ? rd_beats[out_cnt_q] : '0;
  assign m_first  = m_valid & (out_cnt_q == '0);
  assign m_last   = m_valid & last_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q    <= '0;
      asm_q       <= '0;
      cin_start_q <= 1'b0;
      cin_data_q  <= '0;
      sync_q      <= 1'b0;
      ovf_q       <= 1'b0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      cnt_q       <= 2'd0;
      out_cnt_q   <= '0;
      state_q     <= IDLE;
    end else begin
      in_cnt_q    <= in_cnt_d;
      asm_q       <= asm_d;
      cin_start_q <= in_done;
      if (in_done) cin_data_q <= asm_d;
      sync_q      <= sync_q | (s_valid & s_first & (in_cnt_q != '0));
      ovf_q       <= ovf_q | drop;
      if (capture)   wr_sel_q <= ~wr_sel_q;
      if (release_s) rd_sel_q <= ~rd_sel_q;
      cnt_q       <= cnt_d;
      out_cnt_q   <= out_cnt_d;
      state_q     <= state_d;
    end
  end

  // Slot contents need no reset: occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (capture) buf_q[wr_sel_q] <= core_out_data;
  end

  assign core_in_start = cin_start_q;
  assign core_in_data  = cin_data_q;
  assign sync_err      = sync_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_ntt_stream_gearbox.sv
// Bench for ntt_stream_gearbox (LANES=4, 32x32-bit vectors): directed scenarios plus random traffic,
// checked every cycle against a queue-based model of frames and buffered core vectors.
module tb_ntt_stream_gearbox;
  localparam int DW = 32, IPC = 32, L = 4, BEATS = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic s_valid = 1'b0, s_first = 1'b0;
  logic [L*DW-1:0] s_data = '0;
  logic core_in_start;
  logic [IPC-1:0][DW-1:0] core_in_data;
  logic core_out_start = 1'b0;
  logic [IPC-1:0][DW-1:0] core_out_data = '0;
  logic m_valid, m_ready = 1'b0;
  logic [L*DW-1:0] m_data;
  logic m_first, m_last, sync_err, overflow;

  int vectors = 0, miscompares = 0;

  ntt_stream_gearbox #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC), .LANES(L)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_first(s_first), .s_data(s_data),
    .core_in_start(core_in_start), .core_in_data(core_in_data),
    .core_out_start(core_out_start), .core_out_data(core_out_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_first(m_first), .m_last(m_last),
    .sync_err(sync_err), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [IPC-1:0][DW-1:0] m_asm = '0, m_held = '0;
  int  m_inpos = 0, m_beat = 0;
  bit  m_start = 0, m_sync = 0, m_ovf = 0;
  logic [IPC*DW-1:0] outq[$];

  always @(negedge clk) begin
    logic [IPC*DW-1:0] flat;
    bit rel;
    int nq;
    chk("core_in_start", core_in_start, m_start);
    for (int i = 0; i < IPC; i++) chk("core_in_data", core_in_data[i], m_held[i]);
    chk("sync_err", sync_err, m_sync);
    chk("overflow", overflow, m_ovf);
    chk("m_valid", m_valid, outq.size() != 0);
    if (m_valid && outq.size() != 0) begin
      flat = outq[0];
      chk("m_data", m_data, flat[m_beat*L*DW +: L*DW]);
      chk("m_first", m_first, m_beat == 0);
      chk("m_last", m_last, m_beat == BEATS-1);
    end
    if (rst) begin
      m_start = 0; m_held = '0; m_asm = '0; m_inpos = 0;
      m_sync = 0; m_ovf = 0; m_beat = 0; outq.delete();
    end else begin
      nq  = outq.size();
      rel = 0;
      if (m_valid && m_ready && nq > 0) begin
        if (m_beat == BEATS-1) begin
          rel = 1; m_beat = 0; void'(outq.pop_front());
        end else m_beat++;
      end
      if (core_out_start) begin
        if (nq < 2 || rel) outq.push_back(core_out_data);
        else m_ovf = 1;
      end
      m_start = 0;
      if (s_valid) begin
        if (s_first) begin
          if (m_inpos != 0) m_sync = 1;
          m_inpos = 0;
        end
        for (int k = 0; k < L; k++) m_asm[m_inpos*L+k] = s_data[k*DW +: DW];
        m_inpos++;
        if (m_inpos == BEATS) begin
          m_inpos = 0; m_held = m_asm; m_start = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beats(input int base, input int n, input bit first);
    for (int b = 0; b < n; b++) begin
      s_valid = 1'b1;
      s_first = first && (b == 0);
      for (int k = 0; k < L; k++) s_data[k*DW +: DW] = DW'(base + b*L + k);
      tick();
    end
    s_valid = 1'b0; s_first = 1'b0;
  endtask

  task automatic pulse_out(input int base);
    for (int i = 0; i < IPC; i++) core_out_data[i] = DW'(base + i);
    core_out_start = 1'b1;
    tick();
    core_out_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_start", core_in_start, 0);
    chk("rst_flags", {sync_err, overflow}, 0);
    chk("rst_data0", core_in_data[0], 0);
    rst = 1'b0;
    tick();

    // 1: clean frame
    send_beats(0, 8, 1);
    chk("s1_start", core_in_start, 1);
    chk("s1_d5", core_in_data[5], 5);
    chk("s1_d31", core_in_data[31], 31);
    tick();
    chk("s1_start_low", core_in_start, 0);

    // 2: resync mid-frame
    send_beats(500, 3, 1);
    send_beats(100, 8, 1);
    chk("s2_start", core_in_start, 1);
    chk("s2_d0", core_in_data[0], 100);
    chk("s2_d31", core_in_data[31], 131);
    chk("s2_sync", sync_err, 1);
    tick();

    // 3: simple serialisation
    m_ready = 1'b1;
    pulse_out(0);
    chk("s3_valid", m_valid, 1);
    chk("s3_beat0", m_data, {32'd3, 32'd2, 32'd1, 32'd0});
    chk("s3_first", m_first, 1);
    repeat (8) tick();
    chk("s3_idle", m_valid, 0);

    // 4: toggling ready
    m_ready = 1'b0;
    pulse_out(1000);
    for (int c = 0; c < 20; c++) begin
      m_ready = c[0] ? 1'b0 : 1'b1;
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();

    // 5: overflow
    m_ready = 1'b0;
    pulse_out(2000);
    pulse_out(3000);
    pulse_out(4000);
    chk("s5_ovf", overflow, 1);
    chk("s5_hold", m_data[31:0], 2000);
    m_ready = 1'b1;
    repeat (20) tick();
    chk("s5_drained", m_valid, 0);

    // 6: reset mid-serialisation and mid-gather
    pulse_out(5000);
    send_beats(7000, 3, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_valid", m_valid, 0);
    chk("s6_flags", {sync_err, overflow}, 0);
    send_beats(0, 8, 1);
    chk("s6_start", core_in_start, 1);
    chk("s6_d5", core_in_data[5], 5);
    chk("s6_sync", sync_err, 0);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_first = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < L; k++) s_data[k*DW +: DW] = $urandom;
      core_out_start = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < IPC; i++) core_out_data[i] = $urandom;
      m_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    s_valid = 1'b0; s_first = 1'b0; core_out_start = 1'b0; m_ready = 1'b1;
    repeat (40) tick();
    chk("final_drained", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
